// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execution stage.
package instr_register_pkg;

   typedef enum logic [3:0] {
      ZERO  = 4'd0,
      PASSA = 4'd1,
      PASSB = 4'd2,
      ADD   = 4'd3,
      SUB   = 4'd4,
      MULT  = 4'd5,
      DIV   = 4'd6,
      MOD   = 4'd7
   } opcode_t;

   typedef logic signed [31:0] operand_t;
   typedef logic [4:0]         address_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
   } instruction_t;

   // All arithmetic is carried out at this width so no operation can overflow.
   typedef logic signed [63:0] result_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      OUT   = 2'd3
   } exec_state_t;

endpackage

// File: rtl/instr_exec_unit_if.sv
// Result channel of the execution unit: payload plus valid/ready handshake.
interface instr_exec_unit_if;
   import instr_register_pkg::*;

   logic     res_valid;
   logic     res_ready;
   address_t res_addr;
   opcode_t  res_opcode;
   result_t  result;
   logic     div_by_zero;

   modport master (
      output res_valid,
      output res_addr,
      output res_opcode,
      output result,
      output div_by_zero,
      input  res_ready
   );

   modport slave (
      input  res_valid,
      input  res_addr,
      input  res_opcode,
      input  result,
      input  div_by_zero,
      output res_ready
   );

endinterface

// File: rtl/instr_alu.sv
// Combinational ALU: sign-extends both operands to 64 bits and applies the opcode.
module instr_alu
   import instr_register_pkg::*;
(
   input  opcode_t  opc,
   input  operand_t op_a,
   input  operand_t op_b,
   output result_t  result,
   output logic     div_by_zero
);

   result_t a_ext;
   result_t b_ext;

   // Evaluate the opcode; unknown opcodes and division by zero give a zero result.
   always_comb begin
      a_ext       = {{32{op_a[31]}}, op_a};
      b_ext       = {{32{op_b[31]}}, op_b};
      result      = '0;
      div_by_zero = 1'b0;
      case (opc)
         ZERO:  result = '0;
         PASSA: result = a_ext;
         PASSB: result = b_ext;
         ADD:   result = a_ext + b_ext;
         SUB:   result = a_ext - b_ext;
         MULT:  result = a_ext * b_ext;
         DIV: begin
            if (b_ext == '0) div_by_zero = 1'b1;
            else             result      = a_ext / b_ext;
         end
         MOD: begin
            if (b_ext == '0) div_by_zero = 1'b1;
            else             result      = a_ext % b_ext;
         end
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/instr_exec_unit.sv
// Execution stage: walks an address range of the instruction register, executes
// each entry and hands out one result per instruction over a valid/ready channel.
module instr_exec_unit
   import instr_register_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter int RESULT_W = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_W-1:0]   first_addr,
   input  logic [ADDR_W-1:0]   last_addr,
   output logic [ADDR_W-1:0]   read_pointer,
   input  instruction_t        instruction_word,
   instr_exec_unit_if.master   res,
   output logic                busy,
   output logic                done
);

   exec_state_t                state_q, state_d;
   logic [ADDR_W-1:0]          ptr_q, ptr_d;
   logic [ADDR_W-1:0]          end_q, end_d;
   logic [ADDR_W-1:0]          rd_ptr_q, rd_ptr_d;
   instruction_t               iw_q, iw_d;
   logic                       res_valid_q, res_valid_d;
   logic [ADDR_W-1:0]          res_addr_q, res_addr_d;
   opcode_t                    res_opcode_q, res_opcode_d;
   logic signed [RESULT_W-1:0] result_q, result_d;
   logic                       dbz_q, dbz_d;
   logic                       done_q, done_d;

   result_t                    alu_result;
   logic                       alu_dbz;

   instr_alu u_alu (
      .opc         (iw_q.opc),
      .op_a        (iw_q.op_a),
      .op_b        (iw_q.op_b),
      .result      (alu_result),
      .div_by_zero (alu_dbz)
   );

   // Next-state logic: everything holds unless the current state updates it.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      end_d        = end_q;
      rd_ptr_d     = rd_ptr_q;
      iw_d         = iw_q;
      res_valid_d  = res_valid_q;
      res_addr_d   = res_addr_q;
      res_opcode_d = res_opcode_q;
      result_d     = result_q;
      dbz_d        = dbz_q;
      done_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               ptr_d    = first_addr;
               end_d    = last_addr;
               rd_ptr_d = first_addr;
               state_d  = FETCH;
            end
         end
         FETCH: begin
            iw_d    = instruction_word;
            state_d = EXEC;
         end
         EXEC: begin
            result_d     = alu_result;
            dbz_d        = alu_dbz;
            res_addr_d   = ptr_q;
            res_opcode_d = iw_q.opc;
            res_valid_d  = 1'b1;
            state_d      = OUT;
         end
         OUT: begin
            if (res_valid_q && res.res_ready) begin
               res_valid_d = 1'b0;
               if (ptr_q == end_q) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  // Pointer wraps naturally at the top of the address space.
                  ptr_d    = ptr_q + 1'b1;
                  rd_ptr_d = ptr_q + 1'b1;
                  state_d  = FETCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset that also drops any pending result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         end_q        <= '0;
         rd_ptr_q     <= '0;
         iw_q         <= '0;
         res_valid_q  <= 1'b0;
         res_addr_q   <= '0;
         res_opcode_q <= ZERO;
         result_q     <= '0;
         dbz_q        <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         end_q        <= end_d;
         rd_ptr_q     <= rd_ptr_d;
         iw_q         <= iw_d;
         res_valid_q  <= res_valid_d;
         res_addr_q   <= res_addr_d;
         res_opcode_q <= res_opcode_d;
         result_q     <= result_d;
         dbz_q        <= dbz_d;
         done_q       <= done_d;
      end
   end

   assign read_pointer    = rd_ptr_q;
   assign busy            = (state_q != IDLE);
   assign done            = done_q;
   assign res.res_valid   = res_valid_q;
   assign res.res_addr    = res_addr_q;
   assign res.res_opcode  = res_opcode_q;
   assign res.result      = result_q;
   assign res.div_by_zero = dbz_q;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Self-checking bench for instr_exec_unit with a behavioural instruction register.
module tb_instr_exec_unit;
   import instr_register_pkg::*;

   logic         clk;
   logic         reset;
   logic         start;
   logic [4:0]   first_addr;
   logic [4:0]   last_addr;
   logic [4:0]   read_pointer;
   instruction_t instruction_word;
   logic         busy;
   logic         done;

   instr_exec_unit_if res_if ();

   instr_exec_unit #(.ADDR_W(5), .RESULT_W(64)) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .first_addr       (first_addr),
      .last_addr        (last_addr),
      .read_pointer     (read_pointer),
      .instruction_word (instruction_word),
      .res              (res_if),
      .busy             (busy),
      .done             (done)
   );

   instruction_t mem [0:31];
   assign instruction_word = mem[read_pointer];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      opcode_t    opc;
      operand_t   a;
      operand_t   b;
      logic [4:0] addr;
      result_t    exp;
      logic       exp_dbz;
   } vec_t;

   vec_t vecs [0:19];
   int   assert_count = 0;
   int   fail_count   = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      assert_count++;
      if (act !== exp) begin
         fail_count++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic wait_valid(input string name);
      int k;
      k = 0;
      while (res_if.res_valid !== 1'b1 && k < 12) begin
         tick();
         k++;
      end
      check(name, res_if.res_valid, 1);
   endtask

   // Loads a slice of the vector table, runs first..last and checks every result in order.
   task automatic run_vecs(input int base, input int n, input logic [4:0] first,
                           input logic [4:0] last, input int stall_idx);
      for (int i = 0; i < n; i++)
         mem[vecs[base+i].addr] = '{opc: vecs[base+i].opc, op_a: vecs[base+i].a,
                                    op_b: vecs[base+i].b};
      res_if.res_ready = 1'b1;
      first_addr = first;
      last_addr  = last;
      start      = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start", busy, 1);
      for (int i = 0; i < n; i++) begin
         vec_t v;
         v = vecs[base+i];
         if (i == stall_idx) res_if.res_ready = 1'b0;
         wait_valid("res_valid_seen");
         $display("vec %0d: addr=%0d opc=%0d result=%0d dbz=%0b", base + i,
                  res_if.res_addr, res_if.res_opcode, res_if.result, res_if.div_by_zero);
         check("result", res_if.result, v.exp);
         check("div_by_zero", res_if.div_by_zero, v.exp_dbz);
         check("res_addr", res_if.res_addr, v.addr);
         check("res_opcode", res_if.res_opcode, v.opc);
         if (i == stall_idx) begin
            for (int c = 0; c < 4; c++) begin
               if (c == 1) begin
                  start      = 1'b1;
                  first_addr = 5'd5;
                  last_addr  = 5'd5;
               end
               tick();
               start = 1'b0;
               check("stall_valid", res_if.res_valid, 1);
               check("stall_result", res_if.result, v.exp);
               check("stall_addr", res_if.res_addr, v.addr);
               check("stall_read_pointer", read_pointer, v.addr);
            end
            res_if.res_ready = 1'b1;
         end
         // A start on the accepting edge of the last result must not begin a new run.
         if (i == n - 1) start = 1'b1;
         tick();
         start = 1'b0;
         check("valid_drop", res_if.res_valid, 0);
         check("done", done, (i == n - 1) ? 1 : 0);
      end
      tick();
      check("idle_after_done", busy, 0);
      check("done_single_pulse", done, 0);
      check("no_extra_result", res_if.res_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{ZERO,  -7, 2, 5'd0, 0, 1'b0};
      vecs[1]  = '{PASSA, -7, 2, 5'd1, -7, 1'b0};
      vecs[2]  = '{PASSB, -7, 2, 5'd2, 2, 1'b0};
      vecs[3]  = '{ADD,   -7, 2, 5'd3, -5, 1'b0};
      vecs[4]  = '{SUB,   -7, 2, 5'd4, -9, 1'b0};
      vecs[5]  = '{MULT,  -7, 2, 5'd5, -14, 1'b0};
      vecs[6]  = '{DIV,   -7, 2, 5'd6, -3, 1'b0};
      vecs[7]  = '{MOD,   -7, 2, 5'd7, -1, 1'b0};
      vecs[8]  = '{DIV,    9, 0, 5'd10, 0, 1'b1};
      vecs[9]  = '{MOD,    9, 0, 5'd11, 0, 1'b1};
      vecs[10] = '{DIV,    9, 3, 5'd12, 3, 1'b0};
      vecs[11] = '{MOD,    7, -2, 5'd13, 1, 1'b0};
      vecs[12] = '{opcode_t'(4'd12), 9, 3, 5'd14, 0, 1'b0};
      vecs[13] = '{MULT, 32'sh8000_0000, 32'sh8000_0000, 5'd20, 64'sh4000_0000_0000_0000, 1'b0};
      vecs[14] = '{DIV,  32'sh8000_0000, -1, 5'd21, 64'sd2147483648, 1'b0};
      vecs[15] = '{SUB,  100, 1, 5'd30, 99, 1'b0};
      vecs[16] = '{ADD,   -1, -1, 5'd31, -2, 1'b0};
      vecs[17] = '{PASSA, 42, 0, 5'd0, 42, 1'b0};
      vecs[18] = '{MULT,  -3, 4, 5'd1, -12, 1'b0};
      vecs[19] = '{ADD,   10, 20, 5'd3, 30, 1'b0};

      for (int i = 0; i < 32; i++) mem[i] = '0;
      reset            = 1'b1;
      start            = 1'b0;
      first_addr       = '0;
      last_addr        = '0;
      res_if.res_ready = 1'b0;
      tick();
      tick();
      check("rst_read_pointer", read_pointer, 0);
      check("rst_res_valid", res_if.res_valid, 0);
      check("rst_result", res_if.result, 0);
      check("rst_res_opcode", res_if.res_opcode, ZERO);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset = 1'b0;
      tick();

      // Single entry with exact latency: valid appears on the third cycle after start.
      mem[0]           = '{opc: ADD, op_a: 5, op_b: -3};
      res_if.res_ready = 1'b1;
      first_addr       = 5'd0;
      last_addr        = 5'd0;
      start            = 1'b1;
      tick();
      start = 1'b0;
      check("single_busy", busy, 1);
      check("single_valid_c1", res_if.res_valid, 0);
      tick();
      check("single_valid_c2", res_if.res_valid, 0);
      tick();
      $display("single: addr=%0d result=%0d valid=%0b", res_if.res_addr, res_if.result,
               res_if.res_valid);
      check("single_valid_c3", res_if.res_valid, 1);
      check("single_result", res_if.result, 2);
      check("single_addr", res_if.res_addr, 0);
      tick();
      check("single_done", done, 1);
      check("single_idle", busy, 0);
      tick();
      check("single_done_low", done, 0);

      run_vecs(0, 8, 5'd0, 5'd7, -1);
      run_vecs(8, 5, 5'd10, 5'd14, -1);
      run_vecs(13, 2, 5'd20, 5'd21, -1);
      run_vecs(15, 4, 5'd30, 5'd1, 1);

      // Reset while a result is waiting: run aborts with no done pulse.
      res_if.res_ready = 1'b0;
      first_addr       = 5'd3;
      last_addr        = 5'd4;
      start            = 1'b1;
      tick();
      start = 1'b0;
      wait_valid("abort_valid_seen");
      reset = 1'b1;
      tick();
      $display("abort: valid=%0b busy=%0b done=%0b", res_if.res_valid, busy, done);
      check("abort_valid", res_if.res_valid, 0);
      check("abort_result", res_if.result, 0);
      check("abort_addr", res_if.res_addr, 0);
      check("abort_opcode", res_if.res_opcode, ZERO);
      check("abort_dbz", res_if.div_by_zero, 0);
      check("abort_read_pointer", read_pointer, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      reset = 1'b0;
      tick();
      check("abort_no_done", done, 0);
      check("abort_still_idle", busy, 0);
      run_vecs(19, 1, 5'd3, 5'd3, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule

// File: doc/instr_exec_unit.md
Name: instr_exec_unit

Overview:
- Execution stage directly downstream of instr_register.
- Walks read_pointer over a programmed address range and captures each stored instruction_word.
- Evaluates the opcode on the two signed operands and emits one result per instruction over a valid/ready handshake.
- Lets the bench check the register contents end to end through computed results.

Parameters:
- ADDR_W, 5: address width; must equal $bits(address_t) (32 entries).
- RESULT_W, 64: result width; all arithmetic is performed at this width.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run when idle.
- first_addr  input  ADDR_W  first entry of the run; sampled with start.
- last_addr  input  ADDR_W  last entry of the run, inclusive; sampled with start.
- read_pointer  output  ADDR_W  address driven to instr_register.
- instruction_word  input  instruction_t  combinational read data from instr_register.
- res_valid  output  1  result payload valid.
- res_ready  input  1  consumer accepts result.
- res_addr  output  ADDR_W  entry address the result came from.
- res_opcode  output  opcode_t  opcode executed.
- result  output  RESULT_W  signed result.
- div_by_zero  output  1  qualifies the current result; DIV/MOD with op_b==0.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Reset: synchronous, active-high. All outputs go to 0 (read_pointer=0, res_opcode=ZERO) and the FSM goes to IDLE. Reset mid-run aborts the run: no done pulse, and any pending result is dropped.
- FSM states: IDLE, FETCH, EXEC, OUT.
- IDLE: busy=0. On start, latch ptr=first_addr and end=last_addr, then go to FETCH. busy rises the cycle after start.
- FETCH (1 cycle): read_pointer=ptr. On the clock edge, capture instruction_word into iw_q, then go to EXEC.
- EXEC (1 cycle): register the ALU output into result/div_by_zero, set res_addr=ptr and res_opcode=iw_q.opc, set res_valid=1, then go to OUT.
- OUT: hold all payload stable while res_valid=1 and res_ready=0.
- OUT handshake: on res_valid&&res_ready, res_valid falls next cycle.
  - If ptr==end: go to IDLE and pulse done.
  - Else: ptr=ptr+1 modulo 2^ADDR_W, go to FETCH.
- Latency/throughput: start to first res_valid is 3 cycles. Each instruction takes at least 3 cycles when res_ready is tied high.
- Run length: ((last_addr-first_addr) mod 32)+1.
  - last<first wraps through 31 to 0.
  - first==last executes exactly one entry.
- start while busy is ignored. start in the same cycle as the done transition is also ignored; the unit must be IDLE first.
- read_pointer holds its last value outside FETCH.
- Arithmetic: operands are sign-extended to RESULT_W before operating.
  - ZERO → 0
  - PASSA → a
  - PASSB → b
  - ADD → a+b
  - SUB → a-b
  - MULT → full signed 64-bit product
  - DIV → truncated toward zero
  - MOD → remainder; its sign follows a
- DIV/MOD with b==0: result=0 and div_by_zero=1. div_by_zero=0 for all other cases.
- -2^31 DIV -1 yields +2^31 with no overflow.
- Opcode values not in opcode_t produce result=0.

Decomposition:
- instr_register_pkg: opcode_t, operand_t, address_t and instruction_t are already there. Add result_t (signed [63:0]) and exec_state_t (IDLE/FETCH/EXEC/OUT).
- One combinational sub-module, instr_alu:
  - inputs: opcode_t, operand_t a, b
  - outputs: result_t, div_by_zero
- instr_exec_unit holds the FSM, pointer/end registers, the iw_q capture and the output registers.

Test Plan:
- Reset then single entry: entry 0 = {ADD, 5, -3}, start with first=last=0, res_ready=1 → res_valid 3 cycles after start, result=2, res_addr=0, done one cycle after accept, busy=0.
- Full opcode sweep:
  - Setup: entries 0–7 hold ZERO..MOD, each with a=-7, b=2; run first=0, last=7.
  - Results in order: 0, -7, 2, -5, -9, -14, -3, -1.
  - Result count: exactly 8.
- Divide by zero: {DIV, 9, 0} and {MOD, 9, 0} → result=0, div_by_zero=1. The next entry {DIV, 9, 3} → result=3, div_by_zero=0.
- Wrap-around with backpressure:
  - Run first=30, last=1 → res_addr sequence 30, 31, 0, 1.
  - Hold res_ready=0 for 4 cycles on the second result → payload stable, no pointer advance.
  - start pulsed mid-run is ignored.
- Reset mid-run: assert reset while in OUT with res_valid=1 → next cycle all outputs 0, no done pulse. A new start with first=3, last=3 then works normally.
- Extremes: {MULT, -2147483648, -2147483648} → 2^62. {DIV, -2147483648, -1} → 2147483648.
